// File: rtl/micro_program_automate_pkg.sv
// micro_program_automate_pkg
//   Shared definitions for the SM2201 micro-program sequencer.
//   state_t    : sequencer states (IDLE, SETUP, C1, GAP, C2, DONE)
//   CAMAC_ADDR : register address that selects a CAMAC cycle
//   max3       : helper used to size the phase counter
package micro_program_automate_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    C1,
    GAP,
    C2,
    DONE
  } state_t;

  localparam logic [1:0] CAMAC_ADDR = 2'd3;

  function automatic int max3(input int p, input int q, input int r);
    int m;
    m = (p > q) ? p : q;
    return (m > r) ? m : r;
  endfunction

endpackage

// File: rtl/mpa_input_sync.sv
// mpa_input_sync
//   N-bit two-flop synchronizer for asynchronous ISA/CAMAC inputs.
//   Ports:
//     clk   in   system clock
//     reset in   synchronous active-high reset (clears both stages)
//     din   in   N asynchronous inputs
//     dout  out  N synchronized outputs, two clocks behind din
module mpa_input_sync #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);

  logic [N-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      dout <= '0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/micro_program_automate.sv
// micro_program_automate
//   Micro-program sequencer of the SM2201 ISA-CAMAC interface board. Decodes an
//   ISA I/O strobe and, for CAMAC accesses (a == 3), produces the timed c1/c2
//   strobe phases while holding rdy low.
//   Ports:
//     clk    in   system clock (rising edge)
//     reset  in   synchronous active-high reset
//     a      in   register address, 3 = CAMAC cycle
//     w      in   1 = write, 0 = read
//     sel    in   board select, active low
//     tim    in   ISA I/O strobe, active low, falling edge starts a cycle
//     ie     in   X-check enable for CAMAC writes
//     cx1    in   CAMAC X response
//     rdy    out  1 = idle/done
//     c1     out  CAMAC S1 strobe
//     c2     out  CAMAC S2 strobe
//     sel2   out  high for the whole of a CAMAC cycle
//     x0,x1  out  latched address bits while a cycle is active
//   Configuration macro: MPA_INPUT_SYNC_EN adds a 2-flop synchronizer on
//   sel, tim and cx1 (start latency +2 cycles).
module micro_program_automate
  import micro_program_automate_pkg::*;
#(
  parameter int C1_LEN  = 4,
  parameter int GAP_LEN = 2,
  parameter int C2_LEN  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] a,
  input  logic       w,
  input  logic       sel,
  input  logic       tim,
  input  logic       ie,
  input  logic       cx1,
  output logic       rdy,
  output logic       c1,
  output logic       c2,
  output logic       sel2,
  output logic       x0,
  output logic       x1
);

  localparam int CNT_W = $clog2(max3(C1_LEN, GAP_LEN, C2_LEN) + 1);
  localparam logic [CNT_W-1:0] C1_LOAD  = CNT_W'(C1_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] C2_LOAD  = CNT_W'(C2_LEN - 1);

  logic sel_s, tim_s, cx1_s;

`ifdef MPA_INPUT_SYNC_EN
  logic [2:0] sync_out;

  mpa_input_sync #(.N(3)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   ({sel, tim, cx1}),
    .dout  (sync_out)
  );

  assign {sel_s, tim_s, cx1_s} = sync_out;
`else
  assign sel_s = sel;
  assign tim_s = tim;
  assign cx1_s = cx1;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             tim_q;
  logic [1:0]       a_l;
  logic             w_l;
  logic             x_l;
  logic             start;
  logic             active;

  // tim_q clears on reset so a strobe already low when reset drops cannot start a cycle.
  assign start  = !sel_s && tim_q && !tim_s;
  assign active = (state != IDLE);

  // Sequencer, phase counter and output registers. Outputs are a registered
  // decode of the state held during the previous cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      tim_q <= 1'b0;
      a_l   <= '0;
      w_l   <= 1'b0;
      x_l   <= 1'b0;
      rdy   <= 1'b1;
      c1    <= 1'b0;
      c2    <= 1'b0;
      sel2  <= 1'b0;
      x0    <= 1'b0;
      x1    <= 1'b0;
    end else begin
      tim_q <= tim_s;
      rdy   <= (state == IDLE) || (state == DONE);
      c1    <= (state == C1);
      c2    <= (state == C2);
      sel2  <= active && (a_l == CAMAC_ADDR);
      x0    <= active && a_l[0];
      x1    <= active && a_l[1];

      case (state)
        IDLE: begin
          if (start) begin
            a_l   <= a;
            w_l   <= w;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (a_l != CAMAC_ADDR) begin
            state <= DONE;
          end else begin
            state <= C1;
            cnt   <= C1_LOAD;
            // With a one-cycle S1 phase the first C1 cycle is also the last one.
            if (C1_LEN == 1) x_l <= cx1_s;
          end
        end
        C1: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            // X is captured as the sequencer enters the last S1 cycle.
            if (cnt == CNT_W'(1)) x_l <= cx1_s;
          end else if (!w_l || (ie && !x_l)) begin
            state <= DONE;
          end else begin
            state <= GAP;
            cnt   <= GAP_LOAD;
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= C2;
            cnt   <= C2_LOAD;
          end
        end
        C2: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else state <= DONE;
        end
        DONE: begin
          if (tim_s || sel_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_micro_program_automate.sv
// tb_micro_program_automate
//   Self-checking bench for micro_program_automate (default build). A
//   behavioural model tracks each cycle as an offset from its start edge and
//   predicts the outputs; a compare process checks them on every cycle, and
//   directed sequences pin the timing with literal bit masks.
module tb_micro_program_automate;

  localparam int C1_LEN  = 4;
  localparam int GAP_LEN = 2;
  localparam int C2_LEN  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] a = 2'd0;
  logic       w = 1'b0;
  logic       sel = 1'b1;
  logic       tim = 1'b1;
  logic       ie = 1'b0;
  logic       cx1 = 1'b0;
  logic       rdy, c1, c2, sel2, x0, x1;

  int checks = 0;
  int errors = 0;

  micro_program_automate #(
    .C1_LEN  (C1_LEN),
    .GAP_LEN (GAP_LEN),
    .C2_LEN  (C2_LEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .w     (w),
    .sel   (sel),
    .tim   (tim),
    .ie    (ie),
    .cx1   (cx1),
    .rdy   (rdy),
    .c1    (c1),
    .c2    (c2),
    .sel2  (sel2),
    .x0    (x0),
    .x1    (x1)
  );

  always #5 clk = ~clk;

  // Model: rel is the number of cycles since the sequence left IDLE (-1 = idle).
  int         rel = -1;
  int         busy_len = 1;
  logic [1:0] m_a = 2'd0;
  logic       m_tim_q = 1'b0;
  logic       e_rdy = 1'b1, e_c1 = 1'b0, e_c2 = 1'b0, e_sel2 = 1'b0, e_x0 = 1'b0, e_x1 = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      rel     = -1;
      m_tim_q = 1'b0;
      e_rdy = 1'b1; e_c1 = 1'b0; e_c2 = 1'b0; e_sel2 = 1'b0; e_x0 = 1'b0; e_x1 = 1'b0;
    end else begin
      if (rel < 0) begin
        e_rdy = 1'b1; e_c1 = 1'b0; e_c2 = 1'b0; e_sel2 = 1'b0; e_x0 = 1'b0; e_x1 = 1'b0;
      end else begin
        e_rdy  = (rel >= busy_len);
        e_c1   = (m_a == 2'd3) && (rel >= 1) && (rel <= C1_LEN);
        e_c2   = (m_a == 2'd3) && (rel >= 1 + C1_LEN + GAP_LEN) && (rel < busy_len);
        e_sel2 = (m_a == 2'd3);
        e_x0   = m_a[0];
        e_x1   = m_a[1];
      end
      if (rel < 0) begin
        if (!sel && m_tim_q && !tim) begin
          rel = 0;
          m_a = a;
          if (a != 2'd3) busy_len = 1;
          else if (!w || (ie && !cx1)) busy_len = 1 + C1_LEN;
          else busy_len = 1 + C1_LEN + GAP_LEN + C2_LEN;
        end
      end else if (rel >= busy_len) begin
        if (tim || sel) rel = -1;
      end else begin
        rel = rel + 1;
      end
      m_tim_q = tim;
    end
  end

  task automatic checkOutput(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual %0b expected %0b at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model rdy", rdy, e_rdy);
    checkOutput("model c1", c1, e_c1);
    checkOutput("model c2", c2, e_c2);
    checkOutput("model sel2", sel2, e_sel2);
    checkOutput("model x0", x0, e_x0);
    checkOutput("model x1", x1, e_x1);
  end

  task automatic applyStimulus(input logic [1:0] ta, input logic tw, input logic tie,
                               input logic tcx1, input logic tsel, input logic ttim);
    @(negedge clk);
    a = ta; w = tw; ie = tie; cx1 = tcx1; sel = tsel; tim = ttim;
  endtask

  task automatic settle();
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (16) @(negedge clk);
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, " rdy"}, rdy, 1'b1);
    checkOutput({name, " c1"}, c1, 1'b0);
    checkOutput({name, " c2"}, c2, 1'b0);
    checkOutput({name, " sel2"}, sel2, 1'b0);
    checkOutput({name, " x0"}, x0, 1'b0);
    checkOutput({name, " x1"}, x1, 1'b0);
  endtask

  // Bit k of each mask is the expected value k cycles after the start edge.
  task automatic runDirected(input string name, input logic [1:0] ta, input logic tw,
                             input logic tie, input logic tcx1, input logic [15:0] c1_mask,
                             input logic [15:0] c2_mask, input logic [15:0] rdy_mask);
    applyStimulus(ta, tw, tie, tcx1, 1'b0, 1'b1);
    @(negedge clk);
    tim = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s c1 cyc%0d", name, k), c1, c1_mask[k]);
      checkOutput($sformatf("%s c2 cyc%0d", name, k), c2, c2_mask[k]);
      checkOutput($sformatf("%s rdy cyc%0d", name, k), rdy, rdy_mask[k]);
      if (k == 1 || k == 15) begin
        checkOutput($sformatf("%s x0 cyc%0d", name, k), x0, ta[0]);
        checkOutput($sformatf("%s x1 cyc%0d", name, k), x1, ta[1]);
        checkOutput($sformatf("%s sel2 cyc%0d", name, k), sel2, ta == 2'd3);
      end
    end
    tim = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkIdle({name, " release"});
  endtask

  initial begin
    $display("[TB] start");
    // Reset held with sel low and tim toggling: nothing may start.
    sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tim = ~tim;
    end
    checkIdle("reset");
    reset = 1'b0;
    tim = 1'b1;
    sel = 1'b1;
    settle();

    runDirected("local_rd", 2'd1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFD);
    settle();
    runDirected("camac_wr", 2'd3, 1'b1, 1'b0, 1'b1, 16'h003C, 16'h0F00, 16'hF001);
    settle();
    runDirected("camac_rd", 2'd3, 1'b0, 1'b0, 1'b1, 16'h003C, 16'h0000, 16'hFFC1);
    settle();
    runDirected("noX_abort", 2'd3, 1'b1, 1'b1, 1'b0, 16'h003C, 16'h0000, 16'hFFC1);
    settle();
    runDirected("noX_ie0", 2'd3, 1'b1, 1'b0, 1'b0, 16'h003C, 16'h0F00, 16'hF001);
    settle();

    // Reset during the S2 phase, then a deselected strobe.
    applyStimulus(2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    tim = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("midc2 c2 cyc9", c2, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    checkIdle("midc2 reset");
    reset = 1'b0;
    tim = 1'b1;
    sel = 1'b1;
    @(negedge clk);
    tim = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("desel rdy %0d", i), rdy, 1'b1);
      checkOutput($sformatf("desel sel2 %0d", i), sel2, 1'b0);
    end
    settle();

    // Random traffic; ie/cx1 only change while the model is idle.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) tim = ~tim;
      if ($urandom_range(0, 19) == 0) sel = ~sel;
      a = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      if (rel < 0) begin
        ie  = 1'($urandom_range(0, 1));
        cx1 = 1'($urandom_range(0, 1));
      end
    end
    reset = 1'b0;
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
